// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - shared constants, state encoding and word-slice helper for the DMA memory responder
package dma_pkg;

    localparam int DATA_W         = 381;
    localparam int NWORDS         = 12;
    localparam int SR_W           = 32 * NWORDS;
    localparam int PAD_W          = SR_W - DATA_W;
    localparam int CNT_W          = $clog2(NWORDS + 1);
    localparam int TIMEOUT_CYCLES = 1024;

    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NWORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        DONE
    } state_t;

    // Word k sits MSB-first in the padded vector.
    function automatic int word_lsb(input int k);
        return SR_W - 32 * (k + 1);
    endfunction

endpackage

// File: rtl/dma_mem_responder_if.sv
// rtl/dma_mem_responder_if.sv - DMA start/done handshake and req/ack word memory port bundle
interface dma_mem_responder_if;
    import dma_pkg::*;

    logic              dma_rx_start;
    logic [31:0]       dma_rx_address;
    logic [DATA_W-1:0] dma_rx_data;
    logic              dma_tx_start;
    logic [31:0]       dma_tx_address;
    logic [DATA_W-1:0] dma_tx_data;
    logic              dma_done;
    logic              dma_idle;
    logic              dma_error;
    logic              mem_req;
    logic              mem_we;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ack;

    modport slave (
        input  dma_rx_start, dma_rx_address, dma_tx_start, dma_tx_address, dma_tx_data,
        input  mem_rdata, mem_ack,
        output dma_rx_data, dma_done, dma_idle, dma_error,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output dma_rx_start, dma_rx_address, dma_tx_start, dma_tx_address, dma_tx_data,
        output mem_rdata, mem_ack,
        input  dma_rx_data, dma_done, dma_idle, dma_error,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/dma_word_shifter.sv
// rtl/dma_word_shifter.sv - NWORDS x 32 shift register: parallel load for writes, word shift for both directions
module dma_word_shifter
    import dma_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              shift,
    input  logic [DATA_W-1:0] par_in,
    input  logic [31:0]       word_in,
    output logic [31:0]       word_out,
    output logic [DATA_W-1:0] payload_next
);

    logic [SR_W-1:0] sr;
    logic [SR_W-1:0] sr_shifted;

    // Reads shift in at the bottom; writes consume the top word and shift the same way.
    assign sr_shifted   = {sr[SR_W-33:0], word_in};
    assign word_out     = sr[word_lsb(0) +: 32];
    assign payload_next = sr_shifted[SR_W-1 -: DATA_W];

    always_ff @(posedge clk) begin
        if (reset) begin
            sr <= '0;
        end else if (load) begin
            sr <= {par_in, {PAD_W{1'b0}}};
        end else if (shift) begin
            sr <= sr_shifted;
        end
    end

endmodule

// File: rtl/dma_mem_responder.sv
// rtl/dma_mem_responder.sv - DMA start/done responder issuing sequential 32-bit word accesses
// Optional memory-ack watchdog enabled by DMA_RESP_TIMEOUT_EN.
module dma_mem_responder
    import dma_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    dma_mem_responder_if.slave bus
);

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [31:0]       base, base_n;
    logic              error_q, error_n;
    logic [DATA_W-1:0] rx_q, rx_n;
    logic              load, shift, busy, wd_expire;
    logic              rx_mis, tx_mis;
    logic [31:0]       word_out;
    logic [DATA_W-1:0] payload_next;

    dma_word_shifter u_shifter (
        .clk          (clk),
        .reset        (reset),
        .load         (load),
        .shift        (shift),
        .par_in       (bus.dma_tx_data),
        .word_in      (bus.mem_rdata),
        .word_out     (word_out),
        .payload_next (payload_next)
    );

    assign busy   = (state == RD) || (state == WR);
    assign rx_mis = (bus.dma_rx_address[1:0] != 2'b00);
    assign tx_mis = (bus.dma_tx_address[1:0] != 2'b00);

`ifdef DMA_RESP_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd;

    assign wd_expire = busy && !bus.mem_ack && (wd == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            wd <= '0;
        end else if (busy && !bus.mem_ack) begin
            wd <= wd + WD_W'(1);
        end else begin
            wd <= '0;
        end
    end
`else
    assign wd_expire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            base    <= '0;
            error_q <= 1'b0;
            rx_q    <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            base    <= base_n;
            error_q <= error_n;
            rx_q    <= rx_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        base_n  = base;
        error_n = error_q;
        rx_n    = rx_q;
        load    = 1'b0;
        shift   = 1'b0;
        unique case (state)
            IDLE: begin
                // A simultaneous write request is dropped and flagged; the read proceeds.
                if (bus.dma_rx_start) begin
                    base_n  = bus.dma_rx_address;
                    cnt_n   = '0;
                    error_n = bus.dma_tx_start || rx_mis;
                    state_n = rx_mis ? DONE : RD;
                end else if (bus.dma_tx_start) begin
                    base_n  = bus.dma_tx_address;
                    cnt_n   = '0;
                    load    = 1'b1;
                    error_n = tx_mis;
                    state_n = tx_mis ? DONE : WR;
                end
            end
            RD, WR: begin
                if (bus.mem_ack) begin
                    shift = 1'b1;
                    cnt_n = cnt + CNT_W'(1);
                    if (cnt == LAST_WORD) begin
                        state_n = DONE;
                        if (state == RD) begin
                            rx_n = payload_next;
                        end
                    end
                end else if (wd_expire) begin
                    error_n = 1'b1;
                    state_n = DONE;
                end
            end
            DONE: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.dma_done    = (state == DONE);
    assign bus.dma_idle    = (state == IDLE);
    assign bus.dma_error   = error_q;
    assign bus.dma_rx_data = rx_q;
    assign bus.mem_req     = busy;
    assign bus.mem_we      = (state == WR);
    assign bus.mem_addr    = busy ? base + 32'({cnt, 2'b00}) : 32'h0;
    assign bus.mem_wdata   = (state == WR) ? word_out : 32'h0;

endmodule

// File: tb/tb_dma_mem_responder.sv
// tb/tb_dma_mem_responder.sv - scoreboard bench for dma_mem_responder (timeout case under DMA_RESP_TIMEOUT_EN)
module tb_dma_mem_responder;
    import dma_pkg::*;

    localparam int BOUND = 200;

    typedef struct {
        string             name;
        logic [DATA_W-1:0] rx;
        logic              err;
        logic [31:0]       base;
        int                nacc;
        logic              we;
        logic [DATA_W-1:0] wpay;
        int                lat;
        int                start_cyc;
    } exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
    } acc_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    exp_t sb[$];
    acc_t obs[$];
    exp_t mon_e;
    logic [31:0] mem [logic [31:0]];

    int   stall_max = 0;
    int   stall_left = 0;
    bit   withhold = 1'b0;
    bit   spurious = 1'b0;
    int   ack_count = 0;
    bit   held = 1'b0;
    logic [31:0] h_addr, h_wdata;
    logic h_we;

    logic [DATA_W-1:0] model_rx = '0;
    logic              model_err = 1'b0;

    dma_mem_responder_if bus ();

    dma_mem_responder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'h5A5A_0000;
    endfunction

    // Reference: concatenate words MSB-first, then drop the pad bits at the bottom.
    function automatic logic [DATA_W-1:0] model_read(input logic [31:0] b);
        logic [SR_W-1:0] p;
        p = '0;
        for (int k = 0; k < NWORDS; k++) p = (p << 32) | SR_W'(mem_read(b + 32'(4 * k)));
        return DATA_W'(p >> PAD_W);
    endfunction

    function automatic logic [31:0] model_word(input logic [DATA_W-1:0] pay, input int k);
        logic [SR_W-1:0] p;
        p = SR_W'(pay) << PAD_W;
        return 32'(p >> (32 * (NWORDS - 1 - k)));
    endfunction

    // Memory model: random stall per word, records every acked access, checks hold stability.
    always @(negedge clk) begin
        bus.mem_ack = 1'b0;
        if (reset || !bus.mem_req) begin
            held = 1'b0;
            if (!reset && spurious && $urandom_range(0, 3) == 0) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = $urandom;
            end
        end else begin
            if (held) begin
                checks++;
                if (bus.mem_addr !== h_addr || bus.mem_we !== h_we || bus.mem_wdata !== h_wdata) begin
                    errors++;
                    $display("FAIL hold_stable actual addr=%h we=%b wdata=%h required addr=%h we=%b wdata=%h",
                             bus.mem_addr, bus.mem_we, bus.mem_wdata, h_addr, h_we, h_wdata);
                end
            end
            if (withhold || stall_left > 0) begin
                if (stall_left > 0) stall_left--;
                held    = 1'b1;
                h_addr  = bus.mem_addr;
                h_we    = bus.mem_we;
                h_wdata = bus.mem_wdata;
            end else begin
                held = 1'b0;
                bus.mem_ack = 1'b1;
                ack_count++;
                obs.push_back('{we: bus.mem_we, addr: bus.mem_addr});
                if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
                else bus.mem_rdata = mem_read(bus.mem_addr);
                stall_left = $urandom_range(0, stall_max);
            end
        end
    end

    // Scoreboard monitor: every dma_done pops one expected completion.
    always @(negedge clk) begin
        if (!reset && bus.dma_done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=1 required=0");
            end else begin
                int bad;
                mon_e = sb.pop_front();
                chk({mon_e.name, "_error"}, DATA_W'(bus.dma_error), DATA_W'(mon_e.err));
                chk({mon_e.name, "_rx_data"}, bus.dma_rx_data, mon_e.rx);
                chk({mon_e.name, "_n_access"}, DATA_W'(obs.size()), DATA_W'(mon_e.nacc));
                bad = 0;
                for (int k = 0; k < obs.size(); k++)
                    if (k >= mon_e.nacc || obs[k].addr !== mon_e.base + 32'(4 * k) || obs[k].we !== mon_e.we) bad++;
                chk({mon_e.name, "_access_seq_bad"}, DATA_W'(bad), '0);
                if (mon_e.we && mon_e.nacc > 0) begin
                    bad = 0;
                    for (int k = 0; k < NWORDS; k++)
                        if (mem_read(mon_e.base + 32'(4 * k)) !== model_word(mon_e.wpay, k)) bad++;
                    chk({mon_e.name, "_mem_words_bad"}, DATA_W'(bad), '0);
                end
                if (mon_e.lat > 0)
                    chk({mon_e.name, "_latency"}, DATA_W'(cyc - mon_e.start_cyc + 1), DATA_W'(mon_e.lat));
            end
            obs.delete();
        end
    end

    task automatic set_stall(input int m);
        stall_max  = m;
        stall_left = 0;
    endtask

    task automatic run_op(input string nm, input bit rd, input bit wr, input logic [31:0] addr,
                          input logic [DATA_W-1:0] data, input bit poke);
        exp_t e;
        bit   mis, got;
        int   n, busy_bad, post_bad, bound;
        mis    = (addr[1:0] != 2'b00);
        e.name = nm;
        e.base = addr;
        e.we   = !rd;
        e.wpay = data;
        e.nacc = mis ? 0 : NWORDS;
        e.err  = mis || (rd && wr);
        e.rx   = (rd && !mis) ? model_read(addr) : model_rx;
        e.lat  = (stall_max == 0 && !withhold) ? (mis ? 2 : NWORDS + 2) : -1;
        bound  = BOUND;
`ifdef DMA_RESP_TIMEOUT_EN
        if (withhold && !mis) begin
            e.nacc = 0;
            e.err  = 1'b1;
            e.rx   = model_rx;
            e.lat  = TIMEOUT_CYCLES + 2;
        end
        bound = TIMEOUT_CYCLES + 100;
`endif
        @(posedge clk);
        #1;
        bus.dma_rx_start   = rd;
        bus.dma_tx_start   = wr;
        bus.dma_rx_address = addr;
        bus.dma_tx_address = addr;
        bus.dma_tx_data    = data;
        e.start_cyc        = cyc;
        sb.push_back(e);
        @(posedge clk);
        #1;
        bus.dma_rx_start = 1'b0;
        bus.dma_tx_start = 1'b0;
        bus.dma_tx_data  = ~data;
        n = 0;
        busy_bad = 0;
        got = 1'b0;
        while (!got && n < bound) begin
            @(negedge clk);
            if (bus.dma_idle) busy_bad++;
            if (bus.dma_done) got = 1'b1;
            if (poke && n == 3) begin
                bus.dma_rx_start   = 1'b1;
                bus.dma_rx_address = addr + 32'h40;
            end
            if (n == 5) bus.dma_rx_start = 1'b0;
            n++;
        end
        bus.dma_rx_start = 1'b0;
        chk({nm, "_done_seen"}, DATA_W'(got), DATA_W'(1));
        chk({nm, "_idle_low_while_busy_bad"}, DATA_W'(busy_bad), '0);
        post_bad = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (!bus.dma_idle || bus.mem_req || bus.dma_done || bus.dma_error !== e.err) post_bad++;
        end
        chk({nm, "_after_done_bad"}, DATA_W'(post_bad), '0);
        model_rx  = e.rx;
        model_err = e.err;
    endtask

    initial begin
        logic [SR_W-1:0]   cat;
        logic [DATA_W-1:0] d;
        logic [31:0]       a;
        int                a0, n, sel, dones;

        bus.dma_rx_start   = 1'b0;
        bus.dma_tx_start   = 1'b0;
        bus.dma_rx_address = '0;
        bus.dma_tx_address = '0;
        bus.dma_tx_data    = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_idle", DATA_W'(bus.dma_idle), DATA_W'(1));
        chk("rst_done", DATA_W'(bus.dma_done), '0);
        chk("rst_error", DATA_W'(bus.dma_error), '0);
        chk("rst_mem_req", DATA_W'(bus.mem_req), '0);
        chk("rst_mem_we", DATA_W'(bus.mem_we), '0);
        chk("rst_mem_addr", DATA_W'(bus.mem_addr), '0);
        chk("rst_mem_wdata", DATA_W'(bus.mem_wdata), '0);
        chk("rst_rx_data", bus.dma_rx_data, '0);
        @(posedge clk);
        #1 reset = 1'b0;

        for (int k = 0; k < NWORDS; k++) mem[32'h100 + 32'(4 * k)] = 32'(k + 1);
        set_stall(0);
        run_op("rd_0x100", 1'b1, 1'b0, 32'h100, '0, 1'b0);
        for (int k = 0; k < NWORDS; k++) cat[SR_W-1-32*k -: 32] = 32'(k + 1);
        chk("rd_0x100_const", bus.dma_rx_data, cat[SR_W-1 -: DATA_W]);

        run_op("wr_ones", 1'b0, 1'b1, 32'h200, '1, 1'b0);
        chk("wr_ones_word0", DATA_W'(mem_read(32'h200)), DATA_W'(32'hFFFF_FFFF));
        chk("wr_ones_word10", DATA_W'(mem_read(32'h228)), DATA_W'(32'hFFFF_FFFF));
        chk("wr_ones_word11", DATA_W'(mem_read(32'h22C)), DATA_W'(32'hFFFF_FFF8));

        spurious = 1'b1;
        set_stall(5);
        run_op("rd_stall_poke", 1'b1, 1'b0, 32'h1000, '0, 1'b1);
        d = '0;
        for (int k = 0; k < NWORDS; k++) d = (d << 32) | DATA_W'($urandom);
        run_op("wr_stall_poke", 1'b0, 1'b1, 32'h2000, d, 1'b1);

        set_stall(0);
        run_op("rd_misaligned", 1'b1, 1'b0, 32'h102, '0, 1'b0);
        run_op("both_start", 1'b1, 1'b1, 32'h300, d, 1'b0);
        run_op("clean_after_err", 1'b1, 1'b0, 32'h300, '0, 1'b0);
        run_op("wr_misaligned", 1'b0, 1'b1, 32'h403, d, 1'b0);
        run_op("wr_wrap", 1'b0, 1'b1, 32'hFFFF_FFF8, d, 1'b0);
        run_op("rd_wrap", 1'b1, 1'b0, 32'hFFFF_FFF8, '0, 1'b0);
        chk("rd_wrap_matches_write", bus.dma_rx_data, d);

        for (int t = 0; t < 12; t++) begin
            set_stall($urandom_range(0, 5));
            sel = $urandom_range(0, 5);
            a = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 5) == 0) a[0] = 1'b1;
            d = '0;
            for (int k = 0; k < NWORDS; k++) d = (d << 32) | DATA_W'($urandom);
            run_op($sformatf("rand%0d", t), sel != 3 && sel != 4, sel >= 3, a, d, bit'($urandom_range(0, 1)));
        end

        set_stall(0);
        spurious = 1'b0;
        @(posedge clk);
        #1;
        bus.dma_rx_start   = 1'b1;
        bus.dma_rx_address = 32'h500;
        @(posedge clk);
        #1 bus.dma_rx_start = 1'b0;
        a0 = ack_count;
        n = 0;
        while (ack_count < a0 + 5 && n < BOUND) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("rst_mid_reached_5_acks", DATA_W'(ack_count >= a0 + 5), DATA_W'(1));
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid_mem_req", DATA_W'(bus.mem_req), '0);
        chk("rst_mid_idle", DATA_W'(bus.dma_idle), DATA_W'(1));
        chk("rst_mid_rx_data", bus.dma_rx_data, '0);
        @(posedge clk);
        #1 reset = 1'b0;
        obs.delete();
        model_rx  = '0;
        model_err = 1'b0;
        dones = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.dma_done) dones++;
        end
        chk("rst_mid_no_done", DATA_W'(dones), '0);
        run_op("rd_after_rst", 1'b1, 1'b0, 32'h100, '0, 1'b0);

`ifdef DMA_RESP_TIMEOUT_EN
        withhold = 1'b1;
        run_op("timeout_rd", 1'b1, 1'b0, 32'h600, '0, 1'b0);
        withhold = 1'b0;
        run_op("rd_after_timeout", 1'b1, 1'b0, 32'h600, '0, 1'b0);
`endif

        chk("scoreboard_drained", DATA_W'(sb.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dma_mem_responder.md
Name: dma_mem_responder

Overview:
- Responder end of the 381-bit DMA start/done handshake that the ECDSA top drives.
- Services read requests (dma_rx_start) and write requests (dma_tx_start) by issuing sequential 32-bit word accesses on a simple req/ack memory port.
- For reads, assembles the words into dma_rx_data. For writes, splits dma_tx_data into words.
- Used as the memory-side engine in simulation and in the FPGA build, between the crypto top and on-chip/AXI memory.

Parameters:
- DATA_W, 381, payload width of one transfer.
- NWORDS, 12, 32-bit words per transfer; must equal ceil(DATA_W/32).
- TIMEOUT_CYCLES, 1024, maximum cycles to wait for mem_ack; used only with DMA_RESP_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- dma_rx_start  in  1  read request; sampled in IDLE
- dma_rx_address  in  32  byte base address for a read
- dma_rx_data  out  DATA_W  read payload
- dma_tx_start  in  1  write request; sampled in IDLE
- dma_tx_address  in  32  byte base address for a write
- dma_tx_data  in  DATA_W  write payload; captured at accept
- dma_done  out  1  one-cycle completion pulse
- dma_idle  out  1  high only in IDLE
- dma_error  out  1  sticky error flag
- mem_req  out  1  word access request
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  32  word byte address
- mem_wdata  out  32  write word
- mem_rdata  in  32  read word; valid with mem_ack
- mem_ack  in  1  access complete

Behaviour:
- Reset values:
  - state = IDLE; dma_idle = 1.
  - dma_done, dma_error, mem_req, mem_we = 0.
  - mem_addr, mem_wdata, dma_rx_data = 0.
  - Word counter = 0.
- Reset mid-transfer aborts immediately: mem_req drops on the next cycle and no dma_done is issued.
- Word mapping:
  - Padded vector P = {payload, (32*NWORDS-DATA_W) zero bits}.
  - Word k (k = 0..NWORDS-1) lives at base+4k and holds P[32*NWORDS-1-32k -: 32], i.e. MSB word first.
  - Read result: dma_rx_data = P[32*NWORDS-1 -: DATA_W]; pad bits are discarded.
  - Write: the pad bits are written as 0.
- States:
  - IDLE:
    - dma_rx_start → RD, latch address, clear dma_error.
    - else dma_tx_start → WR, latch address and dma_tx_data, clear dma_error.
    - If both are high: the read wins, the write is dropped, and dma_error is set at accept.
    - Address with [1:0] ≠ 0: no memory access; go to DONE with dma_error = 1.
  - RD: mem_req = 1, mem_we = 0, mem_addr = base + 4*cnt.
    - On mem_ack: shift mem_rdata into the assembly register and increment cnt.
    - After the ack for cnt = NWORDS-1 → DONE. The shift is completed in the same cycle, so dma_rx_data is updated on entry to DONE.
  - WR: mem_req = 1, mem_we = 1, mem_wdata = word cnt.
    - On mem_ack: increment cnt.
    - After the last ack → DONE.
  - DONE: dma_done = 1 for exactly one cycle, then → IDLE.
- Memory port rules:
  - mem_req stays high continuously between words; the next word's address is presented the cycle after an ack.
  - mem_addr, mem_we and mem_wdata are stable while mem_req = 1 and no ack has arrived.
  - An ack with mem_req = 0 is ignored.
- Busy handling:
  - dma_idle falls the cycle after accept. This lets an initiator that holds start until ~dma_idle proceed.
  - Starts outside IDLE are ignored and do not queue.
- Latency: accept + NWORDS acks + 1 DONE cycle. With zero-wait ack, dma_done arrives NWORDS+2 cycles after start.
- dma_rx_data holds its value until the next read completes; writes and errors do not change it.
- dma_error stays high until the next accepted start.
- Address arithmetic is modulo 2^32; wrap-around is permitted and not flagged.

Optional Feature:
- Macro: DMA_RESP_TIMEOUT_EN.
- With the macro: a watchdog counts cycles with mem_req = 1 and no mem_ack, resetting on each ack. On reaching TIMEOUT_CYCLES:
  - mem_req drops;
  - dma_error = 1;
  - go to DONE, so dma_done still pulses;
  - for a read, dma_rx_data is not updated.
- Without the macro: the responder waits for mem_ack indefinitely, and no watchdog logic is present.

Decomposition:
- Shared package dma_pkg:
  - DATA_W and NWORDS constants;
  - state enum {IDLE, RD, WR, DONE};
  - word-index-to-slice function.
- One sub-module: dma_word_shifter, the NWORDS×32 shift register. It loads in parallel for writes, shifts in for reads, and shifts out MSB word first for writes.
- The FSM and memory port stay in the top.

Test Plan:
- Read, zero-wait memory: memory at 0x100 holds words 0x00000001..0x0000000C; rx_start at 0x100 → dma_rx_data = {0x00000001,...,0x0000000C}[383:3]; dma_done arrives 14 cycles after start; 12 reads at 0x100..0x12C.
- Write: tx_data = all-ones (381 bits) to 0x200 → words 0..10 = 0xFFFFFFFF, word 11 = 0xFFFFFFF8; single dma_done pulse; dma_rx_data unchanged.
- Handshake and timing: random mem_ack stalls of 0–5 cycles → address and data are held stable during each stall; dma_idle = 0 from the cycle after start until after DONE; a second rx_start pulsed mid-transfer is ignored.
- Errors: rx_start with address 0x102 → no mem_req, dma_error = 1, dma_done pulse; simultaneous rx/tx start at 0x300 → only reads are issued and dma_error = 1; the next clean start clears dma_error.
- Reset and timeout:
  - Reset asserted after the 5th ack → mem_req = 0 and dma_idle = 1 next cycle, with no dma_done.
  - With DMA_RESP_TIMEOUT_EN and mem_ack withheld → dma_error = 1 and dma_done pulse after TIMEOUT_CYCLES.
